drums_note_scheduler: RTL and testbench

Sequences the four falling note lanes of the drum game and feeds the scoring datapath. It owns the game state machine (idle, load, play, over) and fetches note rows from the pattern ROM. It advances each lane's vertical position once per video frame and reloads a lane when it leaves the screen. Its `posL*`/`linea*` outputs drive the scorer and the lane renderer; the scorer's `perdio` ends the game.

---
 rtl/drums_note_scheduler.sv | 177 +++++++++++++++++
 tb/tb_drums_note_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/drums_note_scheduler.sv
// rtl/drums_note_scheduler.sv - drum game lane sequencer: game FSM, pattern ROM fetch, lane motion
// Optional DRUMS_SPEEDUP_EN: step grows by one on each pattern pointer wrap, up to 4*STEP.
module drums_note_scheduler #(
  parameter int SCREEN_LAST  = 479,
  parameter int LANE_SPACING = 120,
  parameter int STEP         = 1,
  parameter int PAT_AW       = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              perdio,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [4:0]        pat_data,
  output logic [9:0]        posL1,
  output logic [9:0]        posL2,
  output logic [9:0]        posL3,
  output logic [9:0]        posL4,
  output logic [4:0]        linea1,
  output logic [4:0]        linea2,
  output logic [4:0]        linea3,
  output logic [4:0]        linea4,
  output logic              score_reset,
  output logic              jugando,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } stateT;

  localparam logic [9:0] LAST = 10'(SCREEN_LAST);

  stateT             curState;
  stateT             nextState;
  logic [PAT_AW-1:0] ptr;
  logic [3:0]        loadCnt;
  logic              refillPhase;
  logic [3:0]        pending;
  logic [3:0]        wrapHit;
  logic [3:0]        capMask;
  logic [9:0]        pos     [4];
  logic [9:0]        posNext [4];
  logic [4:0]        lin     [4];
  logic [9:0]        curStep;
  logic              enterLoad;
  logic              advance;
  logic              capture;
  logic [1:0]        capLane;
  logic [1:0]        refLane;

  // Hold at the last row for one frame before wrapping so the scorer always sees both ends.
  function automatic logic [9:0] stepPos(input logic [9:0] p, input logic [9:0] s);
    logic [10:0] sum;
    sum = {1'b0, p} + {1'b0, s};
    if (p == LAST)
      stepPos = '0;
    else if (sum > {1'b0, LAST})
      stepPos = LAST;
    else
      stepPos = sum[9:0];
  endfunction

  always_comb begin
    nextState = curState;
    case (curState)
      IDLE: if (start) nextState = LOAD;
      LOAD: if (loadCnt == 4'd8) nextState = PLAY;
      PLAY: if (perdio) nextState = OVER;
      OVER: if (start) nextState = LOAD;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)
      curState <= IDLE;
    else
      curState <= nextState;
  end

  always_comb begin
    casez (pending)
      4'b???1: refLane = 2'd0;
      4'b??10: refLane = 2'd1;
      4'b?100: refLane = 2'd2;
      default: refLane = 2'd3;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wrapHit[i] = (pos[i] == LAST);
      posNext[i] = stepPos(pos[i], curStep);
    end
  end

  assign enterLoad = (nextState == LOAD) && (curState != LOAD);
  assign advance   = (curState == PLAY) && frame_tick && !perdio;
  assign capture   = ((curState == LOAD) && loadCnt[0]) ||
                     ((curState == PLAY) && !perdio && refillPhase);
  assign capLane   = (curState == LOAD) ? loadCnt[2:1] : refLane;
  assign capMask   = capture ? (4'b0001 << capLane) : 4'b0000;

  // Each ROM read is two cycles: the address (pointer) sits for one cycle, the row is captured on the next.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      loadCnt     <= '0;
      refillPhase <= 1'b0;
      pending     <= '0;
      score_reset <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pos[i] <= '0;
        lin[i] <= '0;
      end
    end else begin
      score_reset <= enterLoad;
      if (enterLoad) begin
        ptr         <= '0;
        loadCnt     <= '0;
        refillPhase <= 1'b0;
        pending     <= '0;
        for (int i = 0; i < 4; i++)
          pos[i] <= 10'(i * LANE_SPACING);
      end else begin
        if (curState == LOAD)
          loadCnt <= loadCnt + 4'd1;
        if (advance) begin
          for (int i = 0; i < 4; i++)
            pos[i] <= posNext[i];
        end
        if ((curState == PLAY) && !perdio) begin
          pending     <= (pending | (advance ? wrapHit : 4'b0000)) & ~capMask;
          refillPhase <= refillPhase ? 1'b0 : (pending != 4'b0000);
        end
        if (capture) begin
          lin[capLane] <= pat_data;
          ptr          <= ptr + PAT_AW'(1);
        end
      end
    end
  end

`ifdef DRUMS_SPEEDUP_EN
  localparam logic [9:0] STEP_MAX = 10'(4 * STEP);
  logic [9:0] stepReg;

  always_ff @(posedge clk) begin
    if (reset || enterLoad)
      stepReg <= 10'(STEP);
    else if (capture && (ptr == '1) && (stepReg < STEP_MAX))
      stepReg <= stepReg + 10'd1;
  end

  assign curStep = stepReg;
`else
  assign curStep = 10'(STEP);
`endif

  assign pat_addr = ptr;
  assign jugando  = (curState == PLAY);
  assign state    = curState;
  assign posL1    = pos[0];
  assign posL2    = pos[1];
  assign posL3    = pos[2];
  assign posL4    = pos[3];
  assign linea1   = lin[0];
  assign linea2   = lin[1];
  assign linea3   = lin[2];
  assign linea4   = lin[3];

endmodule

// File: tb/tb_drums_note_scheduler.sv
// tb/tb_drums_note_scheduler.sv - self-checking bench for drums_note_scheduler
// Runs a STEP=1 and a STEP=7 instance side by side against a lane/pointer model and a refill scoreboard.
module tb_drums_note_scheduler;

  localparam int LAST       = 479;
  localparam int SPACING    = 120;
  localparam int STEPS [2]  = '{1, 7};

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       perdio;
  logic [4:0] addrO   [2];
  logic [4:0] patData [2];
  logic [9:0] posO    [2][4];
  logic [4:0] linO    [2][4];
  logic       scoreO  [2];
  logic       jugO    [2];
  logic [1:0] stO     [2];
  logic [4:0] rom     [32];

  int checks = 0;
  int errors = 0;
  int tickNo = 0;

  int         mPos  [2][4];
  logic [4:0] mLin  [2][4];
  int         mPtr  [2];
  int         mStep [2];

  typedef struct {
    int         d;
    int         lane;
    logic [4:0] val;
  } refillT;
  refillT sbq [$];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    patData[0] <= rom[addrO[0]];
    patData[1] <= rom[addrO[1]];
  end

  drums_note_scheduler #(.STEP(1)) dutA (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .perdio(perdio),
    .pat_addr(addrO[0]), .pat_data(patData[0]),
    .posL1(posO[0][0]), .posL2(posO[0][1]), .posL3(posO[0][2]), .posL4(posO[0][3]),
    .linea1(linO[0][0]), .linea2(linO[0][1]), .linea3(linO[0][2]), .linea4(linO[0][3]),
    .score_reset(scoreO[0]), .jugando(jugO[0]), .state(stO[0])
  );

  drums_note_scheduler #(.STEP(7)) dutB (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .perdio(perdio),
    .pat_addr(addrO[1]), .pat_data(patData[1]),
    .posL1(posO[1][0]), .posL2(posO[1][1]), .posL3(posO[1][2]), .posL4(posO[1][3]),
    .linea1(linO[1][0]), .linea2(linO[1][1]), .linea3(linO[1][2]), .linea4(linO[1][3]),
    .score_reset(scoreO[1]), .jugando(jugO[1]), .state(stO[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkIdleZero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s state d%0d", tag, d), stO[d], 0);
      check($sformatf("%s jugando d%0d", tag, d), jugO[d], 0);
      check($sformatf("%s score_reset d%0d", tag, d), scoreO[d], 0);
      check($sformatf("%s pat_addr d%0d", tag, d), addrO[d], 0);
      for (int n = 0; n < 4; n++) begin
        check($sformatf("%s pos d%0d L%0d", tag, d, n + 1), posO[d][n], 0);
        check($sformatf("%s linea d%0d L%0d", tag, d, n + 1), linO[d][n], 0);
      end
    end
  endtask

  task automatic checkLoadEntry(input string tag);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s state d%0d", tag, d), stO[d], 1);
      check($sformatf("%s score_reset d%0d", tag, d), scoreO[d], 1);
      for (int n = 0; n < 4; n++)
        check($sformatf("%s pos d%0d L%0d", tag, d, n + 1), posO[d][n], n * SPACING);
    end
  endtask

  task automatic initModelAndCheck(input string tag);
    sbq.delete();
    for (int d = 0; d < 2; d++) begin
      mPtr[d]  = 4;
      mStep[d] = STEPS[d];
      check($sformatf("%s state d%0d", tag, d), stO[d], 2);
      check($sformatf("%s jugando d%0d", tag, d), jugO[d], 1);
      check($sformatf("%s pat_addr d%0d", tag, d), addrO[d], 4);
      for (int n = 0; n < 4; n++) begin
        mPos[d][n] = n * SPACING;
        mLin[d][n] = rom[n];
        check($sformatf("%s pos d%0d L%0d", tag, d, n + 1), posO[d][n], mPos[d][n]);
        check($sformatf("%s linea d%0d L%0d", tag, d, n + 1), linO[d][n], mLin[d][n]);
      end
    end
  endtask

  task automatic doTick(input bit perd, input bit live);
    bit [3:0]   wr     [2];
    int         nWrap  [2];
    int         wLane  [2];
    logic [4:0] oldVal [2];
    logic [4:0] newVal [2];
    refillT     e;
    frame_tick = 1'b1;
    perdio     = perd;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    perdio     = 1'b0;
    tickNo++;
    for (int d = 0; d < 2; d++) begin
      wr[d] = '0; nWrap[d] = 0; wLane[d] = 0; oldVal[d] = '0; newVal[d] = '0;
      if (live) begin
        for (int n = 0; n < 4; n++) begin
          if (mPos[d][n] == LAST) begin
            mPos[d][n] = 0;
            wr[d][n] = 1'b1;
            nWrap[d]++;
            wLane[d] = n;
          end else if (mPos[d][n] + mStep[d] > LAST)
            mPos[d][n] = LAST;
          else
            mPos[d][n] = mPos[d][n] + mStep[d];
        end
        for (int n = 0; n < 4; n++) begin
          if (wr[d][n]) begin
            e.d = d; e.lane = n; e.val = rom[mPtr[d]];
            sbq.push_back(e);
            if (nWrap[d] == 1) begin
              oldVal[d] = mLin[d][n];
              newVal[d] = rom[mPtr[d]];
            end
            mPtr[d] = (mPtr[d] + 1) % 32;
`ifdef DRUMS_SPEEDUP_EN
            if (mPtr[d] == 0 && mStep[d] < 4 * STEPS[d]) mStep[d]++;
`endif
          end
        end
      end
      check($sformatf("tick%0d state d%0d", tickNo, d), stO[d], live ? 2 : 3);
      for (int n = 0; n < 4; n++)
        check($sformatf("tick%0d pos d%0d L%0d", tickNo, d, n + 1), posO[d][n], mPos[d][n]);
    end
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      if (nWrap[d] == 1)
        check($sformatf("tick%0d refill+1 old d%0d L%0d", tickNo, d, wLane[d] + 1),
              linO[d][wLane[d]], oldVal[d]);
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++)
      if (nWrap[d] == 1)
        check($sformatf("tick%0d refill+2 new d%0d L%0d", tickNo, d, wLane[d] + 1),
              linO[d][wLane[d]], newVal[d]);
    repeat (8) @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check($sformatf("tick%0d sb linea d%0d L%0d", tickNo, e.d, e.lane + 1), linO[e.d][e.lane], e.val);
      mLin[e.d][e.lane] = e.val;
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("tick%0d pat_addr d%0d", tickNo, d), addrO[d], mPtr[d]);
      for (int n = 0; n < 4; n++)
        check($sformatf("tick%0d linea d%0d L%0d", tickNo, d, n + 1), linO[d][n], mLin[d][n]);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 5'(i) ^ 5'h0A;
    reset = 1'b1; frame_tick = 1'b0; start = 1'b0; perdio = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkIdleZero("reset");
    reset = 1'b0;

    perdio = 1'b1; frame_tick = 1'b1;
    @(posedge clk); #1;
    perdio = 1'b0; frame_tick = 1'b0;
    checkIdleZero("idle ignores");

    start = 1'b1;
    @(posedge clk); #1;
    checkLoadEntry("start");
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("score_reset one cycle d%0d", d), scoreO[d], 0);
      check($sformatf("start ignored in load d%0d", d), stO[d], 1);
    end
    start = 1'b0; frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) check($sformatf("load k+8 d%0d", d), stO[d], 1);
    @(posedge clk); #1;
    initModelAndCheck("load done");

    for (int i = 1; i <= 510; i++) begin
      doTick(1'b0, 1'b1);
      if (i == 68)  check("B L1 476 tick68", posO[1][0], 476);
      if (i == 69)  check("B L1 sat 479 tick69", posO[1][0], 479);
      if (i == 70)  check("B L1 wrap 0 tick70", posO[1][0], 0);
      if (i == 119) check("A L4 479 tick119", posO[0][3], 479);
      if (i == 120) begin
        check("A L4 wrap 0 tick120", posO[0][3], 0);
        check("A linea4 ROM4", linO[0][3], rom[4]);
      end
    end

    doTick(1'b1, 1'b0);
    for (int d = 0; d < 2; d++) check($sformatf("perdio jugando d%0d", d), jugO[d], 0);
    repeat (5) doTick(1'b0, 1'b0);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checkLoadEntry("restart");
    @(posedge clk); #1;
    for (int d = 0; d < 2; d++) check($sformatf("restart score_reset low d%0d", d), scoreO[d], 0);
    repeat (7) @(posedge clk);
    #1;
    @(posedge clk); #1;
    initModelAndCheck("reload done");

    for (int i = 0; i < 17; i++) doTick(1'b0, 1'b1);
    frame_tick = 1'b1;
    @(posedge clk); #1;
    frame_tick = 1'b0;
    check("B L4 wrap before reset", posO[1][3], 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkIdleZero("reset mid-refill");
    repeat (4) @(posedge clk);
    #1;
    checkIdleZero("after reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
